// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions.
// Holds the redirect sequencer state encoding, the default boot address,
// the control-flow opcodes shared with the branch unit, and a target
// alignment helper.
package msrv32_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPCODE_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPCODE_JAL    = 7'b110_1111;
    localparam logic [6:0] OPCODE_JALR   = 7'b110_0111;

    // A control-flow target must be word aligned (no compressed ISA).
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/msrv32_flush_timer.sv
// 4-bit loadable down-counter used to time the wrong-path flush window.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_val (takes priority over dec)
//   load_val    : value to load
//   dec         : decrement by one (ignored when already zero)
//   zero        : count is zero
module msrv32_flush_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != 4'd0)) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/msrv32_redirect_ctrl.sv
// Control-flow redirect sequencer.
// Turns taken branches and trap requests into a PC-load handshake towards
// fetch, flushes wrong-path instructions for FLUSH_CYCLES cycles after the
// transfer, stalls execute while the redirect is pending, issues the boot
// fetch after reset, flags misaligned taken targets and counts redirects.
// Handshake: a PC transfer occurs in a cycle where pc_load_out and
// fetch_ready_in are both high; while pc_load_out is high and no transfer
// has occurred, pc_target_out holds (only a trap request may replace it).
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in : clock, async active-low reset
//   branch_valid_in, branch_taken_in, target_addr_in : execute-stage branch result
//   trap_req_in, trap_addr_in : trap redirect request (level) and vector
//   fetch_ready_in  : fetch accepts a PC this cycle
//   pc_load_out, pc_target_out : PC-load request and address
//   flush_out, stall_out : kill IF/ID, hold execute
//   misaligned_out  : one-cycle pulse for a misaligned taken target
//   redirect_count_out : saturating count of non-boot transfers
//   state_dbg       : current FSM state
module msrv32_redirect_ctrl
    import msrv32_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        branch_valid_in,
    input  logic        branch_taken_in,
    input  logic [31:0] target_addr_in,
    input  logic        trap_req_in,
    input  logic [31:0] trap_addr_in,
    input  logic        fetch_ready_in,
    output logic        pc_load_out,
    output logic [31:0] pc_target_out,
    output logic        flush_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic [15:0] redirect_count_out,
    output state_e      state_dbg
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] target_d;
    logic        boot_q, boot_d;
    logic        misaligned_d;
    logic        transfer;
    logic        timer_load, timer_dec, timer_zero;
    logic        count_inc;
    logic        branch_taken;

    assign branch_taken = branch_valid_in && branch_taken_in;
    assign transfer     = pc_load_out && fetch_ready_in;
    // The boot fetch is excluded from the redirect count.
    assign count_inc    = transfer && !boot_q && (redirect_count_out != 16'hFFFF);
    assign state_dbg    = state_q;

    msrv32_flush_timer u_flush_timer (
        .clk      (ms_riscv32_mp_clk_in),
        .rst_n    (ms_riscv32_mp_rst_n_in),
        .load     (timer_load),
        .load_val (FLUSH_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = pc_target_out;
        boot_d       = boot_q;
        misaligned_d = 1'b0;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d  = ISSUE;
                target_d = RESET_PC;
                boot_d   = 1'b1;
            end
            IDLE: begin
                // A trap drops any simultaneous branch, including its misaligned flag.
                if (trap_req_in) begin
                    state_d  = ISSUE;
                    target_d = trap_addr_in;
                    boot_d   = 1'b0;
                end else if (branch_taken) begin
                    if (is_word_aligned(target_addr_in)) begin
                        state_d  = ISSUE;
                        target_d = target_addr_in;
                        boot_d   = 1'b0;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (transfer) begin
                    state_d    = FLUSH;
                    timer_load = 1'b1;
                end else if (trap_req_in) begin
                    target_d = trap_addr_in;
                    boot_d   = 1'b0;
                end
            end
            FLUSH: begin
                if (trap_req_in) begin
                    state_d  = ISSUE;
                    target_d = trap_addr_in;
                    boot_d   = 1'b0;
                end else if (timer_zero) begin
                    state_d = IDLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q            <= BOOT;
            boot_q             <= 1'b0;
            pc_load_out        <= 1'b0;
            flush_out          <= 1'b0;
            stall_out          <= 1'b0;
            misaligned_out     <= 1'b0;
            pc_target_out      <= RESET_PC;
            redirect_count_out <= 16'd0;
        end else begin
            state_q        <= state_d;
            boot_q         <= boot_d;
            pc_load_out    <= (state_d == ISSUE);
            flush_out      <= (state_d == ISSUE) || (state_d == FLUSH);
            stall_out      <= (state_d == ISSUE);
            misaligned_out <= misaligned_d;
            pc_target_out  <= target_d;
            if (count_inc) begin
                redirect_count_out <= redirect_count_out + 16'd1;
            end
        end
    end

endmodule
